mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: resetn  in  1  reset, asynchronous and active-low.
REQ-003 SHALL have ports: EXU_to_MEM_valid  in  1  EXU holds a valid instruction; MEM_allow_in  out  1  MEM accepts this cycle.
REQ-004 SHALL have ports: EXU_pc_to_MEM, EXU_inst_to_MEM, EXU_result_to_MEM  in  32 each  pc, instruction, ALU/div result (byte address for loads).
REQ-005 SHALL have ports: EXU_signals_pass_to_MEM  in  13  {res_from_mem[4:0], mem_offsets[1:0], gr_we, dest[4:0]}.
REQ-006 SHALL have ports: res_from_mem one-hot: [4] ld.b, [3] ld.bu, [2] ld.h, [1] ld.hu, [0] ld.w; all-zero means non-load.
REQ-007 SHALL have ports: data_sram_rdata  in  32  synchronous SRAM read data, valid exactly one cycle after the address cycle.
REQ-008 SHALL have ports: WBU_allow_in  in  1; MEM_to_WBU_valid  out  1.
REQ-009 SHALL have ports: MEM_pc_to_WBU, MEM_inst_to_WBU, MEM_result_to_WBU  out  32 each; MEM_to_WBU_gr_we  out  1; MEM_to_WBU_dest  out  5.
REQ-010 SHALL have ports: MEM_to_IDU_gr_we  out  1; MEM_to_IDU_dest  out  5; MEM_to_IDU_valid  out  1; MEM_to_IDU_forward  out  32.

Function
REQ-011 SHALL keep a MEM_valid register; MEM_allow_in = !MEM_valid || WBU_allow_in; ready_go is constant 1.
REQ-012 SHALL load on transfer (EXU_to_MEM_valid && MEM_allow_in): pc, inst, result, res_from_mem, offsets, gr_we, dest into stage registers.
REQ-013 SHALL update MEM_valid <= EXU_to_MEM_valid whenever MEM_allow_in; otherwise hold.
REQ-014 SHALL drive MEM_to_WBU_valid = MEM_valid.
REQ-015 SHALL keep a first_cycle flag: set to 1 on transfer, cleared to 0 on any other edge.
REQ-016 SHALL keep a 32-bit rdata_hold register and rdata_held flag.
REQ-017 SHALL capture data_sram_rdata into rdata_hold and set rdata_held when first_cycle && MEM_valid && !WBU_allow_in.
REQ-018 SHALL clear rdata_held on every transfer into MEM and whenever the stage empties.
REQ-019 SHALL use raw word = rdata_held ? rdata_hold : data_sram_rdata; word is correct in the first cycle and every stalled cycle thereafter.
REQ-020 SHALL select byte = word[8*offsets+7 : 8*offsets] and half = offsets[1] ? word[31:16] : word[15:0].
REQ-021 SHALL extend: ld.b sign-extends byte, ld.bu zero-extends byte, ld.h sign-extends half, ld.hu zero-extends half, ld.w passes word.
REQ-022 SHALL drive MEM_result_to_WBU = load data if res_from_mem != 0, else the registered EXU result.
REQ-023 SHALL ignore offsets[0] for halfword loads (misalignment is not flagged by this block).
REQ-024 SHALL forward to IDU: MEM_to_IDU_valid = MEM_valid, gr_we/dest from stage registers, forward = MEM_result_to_WBU (same cycle, combinational).
REQ-025 SHALL gate MEM_to_WBU_gr_we and MEM_to_IDU_gr_we with MEM_valid.
REQ-026 SHALL, on simultaneous drain to WBU and refill from EXU, take new contents and set first_cycle without stalling.

Reset
REQ-027 SHALL, while resetn=0 (asynchronously): MEM_valid=0, first_cycle=0, rdata_held=0, rdata_hold=0, all stage registers 0.
REQ-028 SHALL then drive: MEM_allow_in=1, MEM_to_WBU_valid=0, MEM_to_IDU_valid=0, all data outputs 0.
REQ-029 SHALL discard an in-flight load entirely on reset mid-operation; first accepted instruction after release behaves as fresh.

Verification
REQ-030 SHALL cover: ld.w, offsets 0, rdata 0x8765_4321, WBU_allow_in=1 -> result 0x8765_4321 one cycle after transfer, valid 1 cycle.
REQ-031 SHALL cover: ld.b offsets 3, rdata 0x80xx_xxxx -> 0xFFFF_FF80; ld.bu same -> 0x0000_0080.
REQ-032 SHALL cover: ld.h offsets 2, rdata 0x8001_1234 -> 0xFFFF_8001; ld.hu offsets 0 -> 0x0000_1234.
REQ-033 SHALL cover: ld.w with WBU_allow_in=0 for 3 cycles, rdata changes to 0xDEAD_BEEF after cycle 1 -> result stays original value, MEM_allow_in=0 throughout.
REQ-034 SHALL cover: back-to-back add (result 0x5) then ld.w, WBU always ready -> results 0x5 then load word, no bubble, forward matches each cycle.
REQ-035 SHALL cover: resetn asserted low mid-stall -> MEM_valid=0 immediately (asynchronous), MEM_allow_in=1, rdata_held=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction between EXU and WBU and
// formats load data from a synchronous SRAM, keeping that data stable across WBU stalls.
module mem_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        EXU_to_MEM_valid,
   output logic        MEM_allow_in,
   input  logic [31:0] EXU_pc_to_MEM,
   input  logic [31:0] EXU_inst_to_MEM,
   input  logic [31:0] EXU_result_to_MEM,
   input  logic [12:0] EXU_signals_pass_to_MEM,
   input  logic [31:0] data_sram_rdata,
   input  logic        WBU_allow_in,
   output logic        MEM_to_WBU_valid,
   output logic [31:0] MEM_pc_to_WBU,
   output logic [31:0] MEM_inst_to_WBU,
   output logic [31:0] MEM_result_to_WBU,
   output logic        MEM_to_WBU_gr_we,
   output logic [4:0]  MEM_to_WBU_dest,
   output logic        MEM_to_IDU_gr_we,
   output logic [4:0]  MEM_to_IDU_dest,
   output logic        MEM_to_IDU_valid,
   output logic [31:0] MEM_to_IDU_forward
);

   // Handshake: an instruction moves EXU->MEM on a rising edge where EXU_to_MEM_valid
   // and MEM_allow_in are both high; MEM->WBU likewise with MEM_to_WBU_valid and
   // WBU_allow_in. ready_go is always 1, so MEM only ever waits on WBU.
   logic        mem_valid;
   logic        first_cycle;
   logic        rdata_held;
   logic [31:0] rdata_hold;
   logic [31:0] pc_r;
   logic [31:0] inst_r;
   logic [31:0] result_r;
   logic [4:0]  res_from_mem_r;
   logic [1:0]  offsets_r;
   logic        gr_we_r;
   logic [4:0]  dest_r;

   logic        transfer;
   logic [31:0] word;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;
   logic [31:0] result_out;

   assign MEM_allow_in = !mem_valid || WBU_allow_in;
   assign transfer     = EXU_to_MEM_valid && MEM_allow_in;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_valid      <= 1'b0;
         first_cycle    <= 1'b0;
         pc_r           <= 32'd0;
         inst_r         <= 32'd0;
         result_r       <= 32'd0;
         res_from_mem_r <= 5'd0;
         offsets_r      <= 2'd0;
         gr_we_r        <= 1'b0;
         dest_r         <= 5'd0;
      end else begin
         first_cycle <= transfer;
         if (MEM_allow_in) mem_valid <= EXU_to_MEM_valid;
         if (transfer) begin
            pc_r           <= EXU_pc_to_MEM;
            inst_r         <= EXU_inst_to_MEM;
            result_r       <= EXU_result_to_MEM;
            res_from_mem_r <= EXU_signals_pass_to_MEM[12:8];
            offsets_r      <= EXU_signals_pass_to_MEM[7:6];
            gr_we_r        <= EXU_signals_pass_to_MEM[5];
            dest_r         <= EXU_signals_pass_to_MEM[4:0];
         end
      end
   end

   // SRAM data is only valid in the first MEM cycle; capture it if WBU stalls us then.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_held <= 1'b0;
         rdata_hold <= 32'd0;
      end else if (MEM_allow_in) begin
         rdata_held <= 1'b0;
      end else if (first_cycle && mem_valid && !WBU_allow_in) begin
         rdata_held <= 1'b1;
         rdata_hold <= data_sram_rdata;
      end
   end

   assign word = rdata_held ? rdata_hold : data_sram_rdata;

   always_comb begin
      ld_byte = word[7:0];
      case (offsets_r)
         2'd0: ld_byte = word[7:0];
         2'd1: ld_byte = word[15:8];
         2'd2: ld_byte = word[23:16];
         2'd3: ld_byte = word[31:24];
         default: ld_byte = word[7:0];
      endcase
      ld_half = offsets_r[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      load_data = word;
      case (res_from_mem_r)
         5'b10000: load_data = {{24{ld_byte[7]}}, ld_byte};
         5'b01000: load_data = {24'd0, ld_byte};
         5'b00100: load_data = {{16{ld_half[15]}}, ld_half};
         5'b00010: load_data = {16'd0, ld_half};
         default:  load_data = word;
      endcase
      result_out = (res_from_mem_r != 5'd0) ? load_data : result_r;
   end

   assign MEM_to_WBU_valid   = mem_valid;
   assign MEM_pc_to_WBU      = pc_r;
   assign MEM_inst_to_WBU    = inst_r;
   assign MEM_result_to_WBU  = result_out;
   assign MEM_to_WBU_gr_we   = gr_we_r && mem_valid;
   assign MEM_to_WBU_dest    = dest_r;
   assign MEM_to_IDU_gr_we   = gr_we_r && mem_valid;
   assign MEM_to_IDU_dest    = dest_r;
   assign MEM_to_IDU_valid   = mem_valid;
   assign MEM_to_IDU_forward = result_out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load formatting, stall hold, back-to-back flow, reset.
module tb_mem_stage;

   logic        clk;
   logic        resetn;
   logic        EXU_to_MEM_valid;
   logic        MEM_allow_in;
   logic [31:0] EXU_pc_to_MEM;
   logic [31:0] EXU_inst_to_MEM;
   logic [31:0] EXU_result_to_MEM;
   logic [12:0] EXU_signals_pass_to_MEM;
   logic [31:0] data_sram_rdata;
   logic        WBU_allow_in;
   logic        MEM_to_WBU_valid;
   logic [31:0] MEM_pc_to_WBU;
   logic [31:0] MEM_inst_to_WBU;
   logic [31:0] MEM_result_to_WBU;
   logic        MEM_to_WBU_gr_we;
   logic [4:0]  MEM_to_WBU_dest;
   logic        MEM_to_IDU_gr_we;
   logic [4:0]  MEM_to_IDU_dest;
   logic        MEM_to_IDU_valid;
   logic [31:0] MEM_to_IDU_forward;

   int n_assert;
   int n_fail;

   localparam logic [4:0] LD_B  = 5'b10000;
   localparam logic [4:0] LD_BU = 5'b01000;
   localparam logic [4:0] LD_H  = 5'b00100;
   localparam logic [4:0] LD_HU = 5'b00010;
   localparam logic [4:0] LD_W  = 5'b00001;
   localparam logic [4:0] NONE  = 5'b00000;

   mem_stage dut (
      .clk                     (clk),
      .resetn                  (resetn),
      .EXU_to_MEM_valid        (EXU_to_MEM_valid),
      .MEM_allow_in            (MEM_allow_in),
      .EXU_pc_to_MEM           (EXU_pc_to_MEM),
      .EXU_inst_to_MEM         (EXU_inst_to_MEM),
      .EXU_result_to_MEM       (EXU_result_to_MEM),
      .EXU_signals_pass_to_MEM (EXU_signals_pass_to_MEM),
      .data_sram_rdata         (data_sram_rdata),
      .WBU_allow_in            (WBU_allow_in),
      .MEM_to_WBU_valid        (MEM_to_WBU_valid),
      .MEM_pc_to_WBU           (MEM_pc_to_WBU),
      .MEM_inst_to_WBU         (MEM_inst_to_WBU),
      .MEM_result_to_WBU       (MEM_result_to_WBU),
      .MEM_to_WBU_gr_we        (MEM_to_WBU_gr_we),
      .MEM_to_WBU_dest         (MEM_to_WBU_dest),
      .MEM_to_IDU_gr_we        (MEM_to_IDU_gr_we),
      .MEM_to_IDU_dest         (MEM_to_IDU_dest),
      .MEM_to_IDU_valid        (MEM_to_IDU_valid),
      .MEM_to_IDU_forward      (MEM_to_IDU_forward)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction from EXU and clock it in; EXU then goes idle.
   task automatic send(input logic [4:0] ld, input logic [1:0] off, input logic [4:0] dest,
                       input logic [31:0] pc, input logic [31:0] res);
      EXU_to_MEM_valid        = 1'b1;
      EXU_pc_to_MEM           = pc;
      EXU_inst_to_MEM         = pc ^ 32'h0F0F_0000;
      EXU_result_to_MEM       = res;
      EXU_signals_pass_to_MEM = {ld, off, 1'b1, dest};
      tick();
      EXU_to_MEM_valid = 1'b0;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      resetn   = 1'b0;
      EXU_to_MEM_valid        = 1'b0;
      EXU_pc_to_MEM           = 32'd0;
      EXU_inst_to_MEM         = 32'd0;
      EXU_result_to_MEM       = 32'd0;
      EXU_signals_pass_to_MEM = 13'd0;
      data_sram_rdata         = 32'd0;
      WBU_allow_in            = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_allow_in", {31'd0, MEM_allow_in}, 32'd1);
      chk("rst_wbu_valid", {31'd0, MEM_to_WBU_valid}, 32'd0);
      chk("rst_idu_valid", {31'd0, MEM_to_IDU_valid}, 32'd0);
      chk("rst_result", MEM_result_to_WBU, 32'd0);
      chk("rst_pc", MEM_pc_to_WBU, 32'd0);
      chk("rst_gr_we", {31'd0, MEM_to_WBU_gr_we}, 32'd0);
      #3 resetn = 1'b1;
      tick();

      // ld.w, offset 0, WBU ready
      send(LD_W, 2'd0, 5'd3, 32'h1c00_0010, 32'h0000_1000);
      data_sram_rdata = 32'h8765_4321;
      #1;
      chk("ldw_valid", {31'd0, MEM_to_WBU_valid}, 32'd1);
      chk("ldw_result", MEM_result_to_WBU, 32'h8765_4321);
      chk("ldw_forward", MEM_to_IDU_forward, 32'h8765_4321);
      chk("ldw_pc", MEM_pc_to_WBU, 32'h1c00_0010);
      chk("ldw_inst", MEM_inst_to_WBU, 32'h130F_0010);
      chk("ldw_dest", {27'd0, MEM_to_WBU_dest}, 32'd3);
      chk("ldw_gr_we", {31'd0, MEM_to_IDU_gr_we}, 32'd1);
      tick();
      chk("ldw_drained", {31'd0, MEM_to_WBU_valid}, 32'd0);
      chk("ldw_gr_we_gated", {31'd0, MEM_to_WBU_gr_we}, 32'd0);

      // Byte and halfword extension
      send(LD_B, 2'd3, 5'd4, 32'h1c00_0020, 32'h0000_2003);
      data_sram_rdata = 32'h8012_3456;
      #1;
      chk("ldb_off3", MEM_result_to_WBU, 32'hFFFF_FF80);
      send(LD_BU, 2'd3, 5'd4, 32'h1c00_0024, 32'h0000_2003);
      data_sram_rdata = 32'h8012_3456;
      #1;
      chk("ldbu_off3", MEM_result_to_WBU, 32'h0000_0080);
      send(LD_B, 2'd1, 5'd4, 32'h1c00_0028, 32'h0000_2001);
      data_sram_rdata = 32'h8001_1234;
      #1;
      chk("ldb_off1", MEM_result_to_WBU, 32'h0000_0012);
      send(LD_H, 2'd2, 5'd5, 32'h1c00_002c, 32'h0000_3002);
      data_sram_rdata = 32'h8001_1234;
      #1;
      chk("ldh_off2", MEM_result_to_WBU, 32'hFFFF_8001);
      send(LD_HU, 2'd0, 5'd5, 32'h1c00_0030, 32'h0000_3000);
      data_sram_rdata = 32'h8001_1234;
      #1;
      chk("ldhu_off0", MEM_result_to_WBU, 32'h0000_1234);
      send(LD_H, 2'd3, 5'd5, 32'h1c00_0034, 32'h0000_3003);
      data_sram_rdata = 32'h8001_1234;
      #1;
      chk("ldh_off3_ignores_bit0", MEM_result_to_WBU, 32'hFFFF_8001);
      send(LD_HU, 2'd2, 5'd5, 32'h1c00_0038, 32'h0000_3002);
      data_sram_rdata = 32'h0000_9234;
      #1;
      chk("ldhu_off2_zero", MEM_result_to_WBU, 32'h0000_0000);
      tick();

      // ld.w stalled by WBU for 3 cycles; SRAM data changes after the first
      WBU_allow_in = 1'b0;
      send(LD_W, 2'd0, 5'd6, 32'h1c00_0040, 32'h0000_4000);
      data_sram_rdata = 32'h1122_3344;
      #1;
      chk("stall_c1_result", MEM_result_to_WBU, 32'h1122_3344);
      chk("stall_c1_allow_in", {31'd0, MEM_allow_in}, 32'd0);
      tick();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("stall_c2_result", MEM_result_to_WBU, 32'h1122_3344);
      chk("stall_c2_allow_in", {31'd0, MEM_allow_in}, 32'd0);
      tick();
      chk("stall_c3_result", MEM_result_to_WBU, 32'h1122_3344);
      chk("stall_c3_forward", MEM_to_IDU_forward, 32'h1122_3344);
      chk("stall_c3_allow_in", {31'd0, MEM_allow_in}, 32'd0);
      chk("stall_c3_valid", {31'd0, MEM_to_WBU_valid}, 32'd1);
      WBU_allow_in = 1'b1;
      #1;
      chk("stall_release_allow_in", {31'd0, MEM_allow_in}, 32'd1);
      chk("stall_release_result", MEM_result_to_WBU, 32'h1122_3344);
      tick();
      chk("stall_drained", {31'd0, MEM_to_WBU_valid}, 32'd0);

      // Back-to-back add then ld.w, no bubble
      EXU_to_MEM_valid        = 1'b1;
      EXU_pc_to_MEM           = 32'h1c00_0050;
      EXU_inst_to_MEM         = 32'h0010_1485;
      EXU_result_to_MEM       = 32'h0000_0005;
      EXU_signals_pass_to_MEM = {NONE, 2'd0, 1'b1, 5'd7};
      tick();
      EXU_pc_to_MEM           = 32'h1c00_0054;
      EXU_inst_to_MEM         = 32'h2880_0108;
      EXU_result_to_MEM       = 32'h0000_5000;
      EXU_signals_pass_to_MEM = {LD_W, 2'd0, 1'b1, 5'd8};
      data_sram_rdata         = 32'hAAAA_5555;
      #1;
      chk("b2b_add_result", MEM_result_to_WBU, 32'h0000_0005);
      chk("b2b_add_forward", MEM_to_IDU_forward, 32'h0000_0005);
      chk("b2b_add_dest", {27'd0, MEM_to_IDU_dest}, 32'd7);
      chk("b2b_add_allow_in", {31'd0, MEM_allow_in}, 32'd1);
      tick();
      EXU_to_MEM_valid = 1'b0;
      data_sram_rdata  = 32'hCAFE_F00D;
      #1;
      chk("b2b_ld_valid", {31'd0, MEM_to_WBU_valid}, 32'd1);
      chk("b2b_ld_result", MEM_result_to_WBU, 32'hCAFE_F00D);
      chk("b2b_ld_forward", MEM_to_IDU_forward, 32'hCAFE_F00D);
      chk("b2b_ld_dest", {27'd0, MEM_to_WBU_dest}, 32'd8);
      chk("b2b_ld_pc", MEM_pc_to_WBU, 32'h1c00_0054);
      tick();
      chk("b2b_drained", {31'd0, MEM_to_IDU_valid}, 32'd0);

      // Reset asserted mid-stall
      WBU_allow_in = 1'b0;
      send(LD_W, 2'd0, 5'd9, 32'h1c00_0060, 32'h0000_6000);
      data_sram_rdata = 32'h5A5A_0001;
      tick();
      data_sram_rdata = 32'h0000_0000;
      #1;
      chk("pre_rst_held", {31'd0, dut.rdata_held}, 32'd1);
      chk("pre_rst_result", MEM_result_to_WBU, 32'h5A5A_0001);
      #2;
      resetn = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, MEM_to_WBU_valid}, 32'd0);
      chk("midrst_allow_in", {31'd0, MEM_allow_in}, 32'd1);
      chk("midrst_held", {31'd0, dut.rdata_held}, 32'd0);
      chk("midrst_result", MEM_result_to_WBU, 32'd0);
      chk("midrst_gr_we", {31'd0, MEM_to_IDU_gr_we}, 32'd0);
      tick();
      resetn       = 1'b1;
      WBU_allow_in = 1'b1;
      tick();
      send(LD_BU, 2'd0, 5'd10, 32'h1c00_0070, 32'h0000_7000);
      data_sram_rdata = 32'h1234_56FF;
      #1;
      chk("post_rst_ldbu", MEM_result_to_WBU, 32'h0000_00FF);
      chk("post_rst_valid", {31'd0, MEM_to_WBU_valid}, 32'd1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
